// File: rtl/coeff_loader_if.sv
// Bus bundle for coeff_loader: load stream in, readback stream out, and the
// single-port SRAM strobes. The loader drives through "master", its peers through "slave".
interface coeff_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic              sram_wen;
  logic              sram_ren;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    input  s_valid, s_data, m_ready, sram_rdata,
    output s_ready, m_valid, m_data, sram_wen, sram_ren, sram_addr, sram_wdata
  );

  modport slave (
    output s_valid, s_data, m_ready, sram_rdata,
    input  s_ready, m_valid, m_data, sram_wen, sram_ren, sram_addr, sram_wdata
  );
endinterface

// File: rtl/coeff_loader.sv
// Coefficient SRAM loader: streams a block of words into the SRAM or reads a block
// back out as a stream, keeping a modular checksum of the words moved.
module coeff_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  coeff_loader_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {IDLE, LOAD, RD_REQ, RD_WAIT, RD_OUT, FIN} state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] word);
    return acc + word;
  endfunction

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   idx;
  logic [DATA_W-1:0] csum;
  logic [DATA_W-1:0] rd_word_p1;
  logic              err_q;
  logic              start_ok;
  logic              last_word;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W-1:0] cur_addr;

  assign start_ok  = start && (count != '0) && (count <= MAX_CNT);
  assign last_word = (idx == cnt_q - ONE);
  assign idx_inc   = idx + ONE;
  // Address wraps naturally through the ADDR_W-bit add.
  assign cur_addr  = base_q + idx[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      idx        <= '0;
      csum       <= '0;
      rd_word_p1 <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            csum <= '0;
            if (start_ok) begin
              base_q <= base_addr;
              cnt_q  <= count;
              idx    <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.s_valid) begin
            idx  <= idx_inc;
            csum <= csum_add(csum, bus.s_data);
          end
        end
        // SRAM read data lands here, one cycle after the read strobe
        RD_WAIT: rd_word_p1 <= bus.sram_rdata;
        RD_OUT: begin
          if (bus.m_ready) begin
            idx  <= idx_inc;
            csum <= csum_add(csum, rd_word_p1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = mode ? RD_REQ : LOAD;
      LOAD:    if (bus.s_valid && last_word) state_nxt = FIN;
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = RD_OUT;
      RD_OUT:  if (bus.m_ready) state_nxt = last_word ? FIN : RD_REQ;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are gated by rst so a reset mid-load can never slip a write through.
  always_comb begin
    bus.s_ready    = 1'b0;
    bus.m_valid    = 1'b0;
    bus.sram_wen   = 1'b0;
    bus.sram_ren   = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    case (state)
      LOAD: begin
        bus.s_ready    = ~rst;
        bus.sram_wen   = bus.s_valid & ~rst;
        bus.sram_addr  = cur_addr;
        bus.sram_wdata = bus.s_data;
      end
      RD_REQ: begin
        bus.sram_ren  = ~rst;
        bus.sram_addr = cur_addr;
      end
      RD_OUT:  bus.m_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.m_data = rd_word_p1;
  assign busy       = (state != IDLE);
  assign done       = (state == FIN) || err_q;
  assign err        = err_q;
  assign checksum   = csum;

endmodule

// File: tb/tb_coeff_loader.sv
// Bench for coeff_loader: table of transfers with a write/read scoreboard and an
// SRAM model, plus hand sequences for reset and start corner cases.
module tb_coeff_loader;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          busy, done, err;
  logic [DW-1:0] checksum;

  coeff_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  coeff_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .count(count), .bus(bus), .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sram    [256];
  logic [DW-1:0] ref_mem [256];

  always @(posedge clk) begin
    if (bus.sram_wen) sram[bus.sram_addr] <= bus.sram_wdata;
    if (bus.sram_ren) bus.sram_rdata <= sram[bus.sram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          mode;
    logic [7:0]    base;
    logic [8:0]    cnt;
    logic [31:0]   first;
    logic [31:0]   step;
    logic          gap;
    logic          poke;
    int            stall;
    logic          exp_err;
    logic [31:0]   csum;
  } vec_t;

  vec_t tbl [13];

  logic [7:0]  exp_wa [$];
  logic [31:0] exp_wd [$];
  logic [31:0] exp_rd [$];

  int n_vec = 0, n_bad = 0;
  int done_cnt = 0, err_cnt = 0, wen_cnt = 0, ren_cnt = 0;
  int wr_base = 0, first_wr_cyc = 0, done_cyc = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.sram_wen && bus.sram_ren) check("wen_ren_exclusive", 32'd1, 32'd0);
      if (bus.sram_wen) begin
        if (wen_cnt == wr_base) first_wr_cyc = cyc;
        wen_cnt++;
        if (exp_wa.size() == 0) check("write_expected", exp_wa.size(), 32'd1);
        else begin
          check("wr_addr", {24'd0, bus.sram_addr}, {24'd0, exp_wa.pop_front()});
          check("wr_data", bus.sram_wdata, exp_wd.pop_front());
        end
      end
      if (bus.sram_ren) ren_cnt++;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_rd.size() == 0) check("read_expected", exp_rd.size(), 32'd1);
        else check("rd_data", bus.m_data, exp_rd.pop_front());
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) begin
        err_cnt++;
        check("err_with_done", {31'd0, done}, 32'd1);
      end
      if (!busy)
        check("idle_quiet", {28'd0, bus.s_ready, bus.m_valid, bus.sram_wen, bus.sram_ren}, 32'd0);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_err"},   {31'd0, err}, 32'd0);
    check({tag, "_csum"},  checksum, 32'd0);
    check({tag, "_strobes"}, {28'd0, bus.s_ready, bus.m_valid, bus.sram_wen, bus.sram_ren}, 32'd0);
    check({tag, "_mdata"}, bus.m_data, 32'd0);
    check({tag, "_addr"},  {24'd0, bus.sram_addr}, 32'd0);
    check({tag, "_wdata"}, bus.sram_wdata, 32'd0);
  endtask

  task automatic run_xfer(input vec_t v);
    int d0, e0, w0, r0, t0, g;
    logic [7:0]  a;
    logic [31:0] w;
    d0 = done_cnt; e0 = err_cnt; w0 = wen_cnt; r0 = ren_cnt;
    wr_base = wen_cnt;
    @(posedge clk) #1;
    start = 1'b1; mode = v.mode; base_addr = v.base; count = v.cnt;
    @(posedge clk) #1;
    start = 1'b0;
    t0 = cyc;
    if (v.exp_err) begin
      @(negedge clk);
      check("illegal_err", {31'd0, err}, 32'd1);
      check("illegal_done", {31'd0, done}, 32'd1);
      check("illegal_busy", {31'd0, busy}, 32'd0);
      @(posedge clk) #1;
      @(negedge clk);
      check("illegal_err_once", {31'd0, err}, 32'd0);
      check("illegal_busy2", {31'd0, busy}, 32'd0);
      check("illegal_no_access", wen_cnt - w0 + ren_cnt - r0, 32'd0);
      check("illegal_csum", checksum, 32'd0);
      return;
    end
    if (!v.mode) begin
      for (int i = 0; i < int'(v.cnt); i++) begin
        if (v.gap && i == 1) begin
          bus.s_valid = 1'b0;
          @(posedge clk) #1;
        end
        a = v.base + 8'(i);
        w = v.first + v.step * i;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        exp_wa.push_back(a);
        exp_wd.push_back(w);
        ref_mem[a] = w;
        if (v.poke && i == 1) begin
          start = 1'b1; mode = 1'b1; base_addr = 8'h00; count = 9'd1;
        end
        @(posedge clk) #1;
        start = 1'b0;
      end
      bus.s_valid = 1'b0;
    end else begin
      for (int i = 0; i < int'(v.cnt); i++) begin
        a = v.base + 8'(i);
        exp_rd.push_back(ref_mem[a]);
      end
      if (v.stall < 0) begin
        bus.m_ready = 1'b1;
      end else begin
        for (int i = 0; i < int'(v.cnt); i++) begin
          g = 0;
          do begin @(negedge clk); g++; end while (!bus.m_valid && g < 100);
          check("mvalid_timeout", {31'd0, bus.m_valid}, 32'd1);
          if (i == v.stall) begin
            w = bus.m_data;
            repeat (2) begin
              @(posedge clk) #1;
              @(negedge clk);
              check("stall_mvalid", {31'd0, bus.m_valid}, 32'd1);
              check("stall_hold", bus.m_data, w);
            end
          end
          @(posedge clk) #1;
          bus.m_ready = 1'b1;
          @(posedge clk) #1;
          bus.m_ready = 1'b0;
        end
      end
    end
    g = 0;
    while (done_cnt == d0 && g < 2000) begin @(posedge clk); g++; end
    check("done_timeout", {31'd0, (g < 2000)}, 32'd1);
    @(posedge clk) #1;
    bus.m_ready = 1'b0;
    @(negedge clk);
    check("done_once", done_cnt - d0, 32'd1);
    check("no_err", err_cnt - e0, 32'd0);
    check("checksum", checksum, v.csum);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("queues_drained", exp_wa.size() + exp_rd.size(), 32'd0);
    check("wr_count", wen_cnt - w0, v.mode ? 32'd0 : 32'(v.cnt));
    check("rd_count", ren_cnt - r0, v.mode ? 32'(v.cnt) : 32'd0);
    if (!v.gap && !v.poke && v.stall < 0) begin
      if (!v.mode) check("first_write_cycle", first_wr_cyc - t0, 32'd0);
      check("done_latency", done_cyc - t0, v.mode ? 32'(3 * v.cnt) : 32'(v.cnt));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            mode base   cnt      first         step       gap  poke stall err  csum
    tbl[0]  = '{1'b0, 8'h80, 9'd256, 32'd0,        32'd1,     1'b1, 1'b0, -1, 1'b0, 32'h0000_7F80};
    tbl[1]  = '{1'b1, 8'h80, 9'd256, 32'd0,        32'd0,     1'b0, 1'b0, -1, 1'b0, 32'h0000_7F80};
    tbl[2]  = '{1'b0, 8'h10, 9'd4,   32'd1,        32'd1,     1'b0, 1'b0, -1, 1'b0, 32'd10};
    tbl[3]  = '{1'b0, 8'hFE, 9'd3,   32'h100,      32'h100,   1'b0, 1'b0, -1, 1'b0, 32'h600};
    tbl[4]  = '{1'b1, 8'h10, 9'd4,   32'd0,        32'd0,     1'b0, 1'b0,  1, 1'b0, 32'd10};
    tbl[5]  = '{1'b0, 8'h00, 9'd0,   32'd0,        32'd0,     1'b0, 1'b0, -1, 1'b1, 32'd0};
    tbl[6]  = '{1'b0, 8'h00, 9'd257, 32'd0,        32'd0,     1'b0, 1'b0, -1, 1'b1, 32'd0};
    tbl[7]  = '{1'b0, 8'h40, 9'd2,   32'hFFFFFFFF, 32'd0,     1'b0, 1'b0, -1, 1'b0, 32'hFFFF_FFFE};
    tbl[8]  = '{1'b1, 8'hFE, 9'd3,   32'd0,        32'd0,     1'b0, 1'b0, -1, 1'b0, 32'h600};
    tbl[9]  = '{1'b0, 8'h60, 9'd3,   32'd7,        32'd7,     1'b0, 1'b1, -1, 1'b0, 32'd42};
    tbl[10] = '{1'b1, 8'h40, 9'd2,   32'd0,        32'd0,     1'b0, 1'b0,  0, 1'b0, 32'hFFFF_FFFE};
    tbl[11] = '{1'b0, 8'h33, 9'd1,   32'hDEADBEEF, 32'd0,     1'b0, 1'b0, -1, 1'b0, 32'hDEAD_BEEF};
    tbl[12] = '{1'b0, 8'hA0, 9'd8,   32'h9000,     32'd1,     1'b0, 1'b0, -1, 1'b0, 32'h0004_801C};

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; count = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk) #1;
    rst = 1'b0;
    mon_en = 1'b1;

    for (int k = 0; k < 12; k++) run_xfer(tbl[k]);

    // start coincident with reset is dropped
    @(posedge clk) #1;
    rst = 1'b1; start = 1'b1; mode = 1'b0; base_addr = 8'h20; count = 9'd4;
    @(posedge clk) #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    check("rst_start_err", {31'd0, err}, 32'd0);

    // reset after three writes of an eight-word load
    begin
      int d0;
      logic [7:0] a;
      d0 = done_cnt;
      wr_base = wen_cnt;
      @(posedge clk) #1;
      start = 1'b1; mode = 1'b0; base_addr = 8'hA0; count = 9'd8;
      @(posedge clk) #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        a = 8'hA0 + 8'(i);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h5000 + i;
        exp_wa.push_back(a);
        exp_wd.push_back(32'h5000 + i);
        ref_mem[a] = 32'h5000 + i;
        @(posedge clk) #1;
      end
      bus.s_data = 32'h5003;
      rst = 1'b1;
      @(negedge clk);
      check("rst_gates_wen", {31'd0, bus.sram_wen}, 32'd0);
      check("rst_gates_sready", {31'd0, bus.s_ready}, 32'd0);
      @(posedge clk) #1;
      bus.s_valid = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      @(posedge clk) #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("midrst_no_done", done_cnt - d0, 32'd0);
      for (int i = 0; i < 8; i++) begin
        a = 8'hA0 + 8'(i);
        check("midrst_sram", sram[a], ref_mem[a]);
      end
      check("midrst_queue", exp_wa.size(), 32'd0);
    end

    run_xfer(tbl[12]);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/coeff_loader.md
COEFF_LOADER -- requirements
Module: coeff_loader

Interface
REQ-001: Parameter ADDR_W, default 8, SRAM address width (depth 2^ADDR_W = 256 words).
REQ-002: Parameter DATA_W, default 32, coefficient word width.
REQ-003: clk  input  1  single clock; all state changes on rising edge.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006: mode  input  1  0 = load (stream -> SRAM), 1 = readback (SRAM -> stream); sampled with start.
REQ-007: base_addr  input  8  first SRAM address; sampled with start.
REQ-008: count  input  9  word count, legal 1..256; sampled with start.
REQ-009: s_valid / s_data[31:0] / s_ready  input / input / output  load-mode input stream.
REQ-010: m_valid / m_data[31:0] / m_ready  output / output / input  readback output stream.
REQ-011: sram_wen, sram_ren  output  1 each  SRAM write / read strobes.
REQ-012: sram_addr  output  8  SRAM address; sram_wdata  output  32  SRAM write data.
REQ-013: sram_rdata  input  32  SRAM read data, valid the cycle after sram_ren is sampled.
REQ-014: busy  output  1  high in any state other than IDLE.
REQ-015: done  output  1  one-cycle pulse at transfer end; err  output  1  one-cycle pulse, illegal count.
REQ-016: checksum  output  32  running sum mod 2^32 of words transferred in the current/last transfer.

Function
REQ-017: States IDLE, LOAD, RD_REQ, RD_WAIT, RD_OUT, FIN; encoding free.
REQ-018: IDLE + start + count in 1..256: latch base_addr, count, mode; clear index and checksum; go LOAD (mode 0) or RD_REQ (mode 1).
REQ-019: IDLE + start + count 0 or >256: no SRAM access, err and done both pulse the next cycle, checksum cleared, remain IDLE.
REQ-020: start outside IDLE ignored.
REQ-021: Current address = (latched base + index) mod 256; wrap past 255 to 0 without error.
REQ-022: LOAD: s_ready = 1; sram_wen = s_valid, sram_addr = current address, sram_wdata = s_data, all combinational; write occurs at that edge.
REQ-023: LOAD handshake (s_valid & s_ready): index += 1, checksum += s_data; after the count-th word go FIN.
REQ-024: s_ready = 0 in every state except LOAD; s_valid low in LOAD stalls with no write.
REQ-025: RD_REQ: sram_ren = 1, sram_addr = current address for exactly one cycle; go RD_WAIT.
REQ-026: RD_WAIT: capture sram_rdata into output register; go RD_OUT.
REQ-027: RD_OUT: m_valid = 1, m_data = captured word, held stable until m_ready; on m_valid & m_ready: checksum += m_data, index += 1, go RD_REQ, or FIN after the count-th word.
REQ-028: Readback throughput 1 word per 3 cycles minimum; no pipelined reads.
REQ-029: FIN: done = 1 for one cycle; go IDLE. checksum holds until the next accepted start.
REQ-030: sram_wen and sram_ren never both high; both low outside LOAD/RD_REQ.
REQ-031: m_valid low in every state except RD_OUT.

Reset
REQ-032: rst high at a clock edge: state IDLE; index, checksum, m_data, latched fields = 0; busy, done, err, m_valid, s_ready, sram_wen, sram_ren = 0; sram_addr, sram_wdata = 0.
REQ-033: While rst is high, sram_wen and sram_ren are forced 0 combinationally, even mid-LOAD with s_valid high.
REQ-034: rst mid-transfer abandons it with no done pulse; words already written remain in SRAM.
REQ-035: start coincident with rst ignored.

Verification
REQ-036: Load base 0x10, count 4, data 1,2,3,4 with continuous s_valid -> writes to 0x10..0x13 on 4 consecutive cycles, done one cycle later, checksum 10.
REQ-037: Load base 0xFE, count 3 -> writes to 0xFE, 0xFF, 0x00; no err.
REQ-038: Readback base 0x10, count 4 over the REQ-036 contents, m_ready low 2 cycles on word 2 -> m_data 1,2,3,4 in order, word 2 held stable, checksum 10, done once.
REQ-039: start with count 0, then count 257 -> err + done each pulse one cycle, no sram_wen/sram_ren, busy stays 0.
REQ-040: Load count 8, rst after 3 writes -> all outputs 0 next cycle, no done, SRAM 0..2 written, 3..7 untouched; a new start then completes normally.
REQ-041: Load 0xFFFFFFFF twice -> checksum 0xFFFFFFFE (mod 2^32 wrap).
